fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000, sets the PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16, is the number of direct-mapped BTB entries; it SHALL be a power of 2 between 4 and 64.
REQ-003 CLK  in  1  rising-edge clock for all state.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 imemREN  out  1  instruction memory read request.
REQ-006 imemaddr  out  32  fetch address; always equals PC.
REQ-007 ihit  in  1  imemload is valid this cycle.
REQ-008 imemload  in  32  fetched instruction word.
REQ-009 stall  in  1  hazard unit holds IF/ID and PC.
REQ-010 ex_redirect  in  1  mispredict/jump resolved in EX.
REQ-011 ex_target  in  32  correct next PC when ex_redirect=1.
REQ-012 btb_upd  in  1  resolved branch update strobe.
REQ-013 btb_upd_pc  in  32  PC of the resolved branch.
REQ-014 btb_upd_target  in  32  branch target of the resolved branch.
REQ-015 btb_upd_taken  in  1  actual branch outcome.
REQ-016 halt  in  1  HALT decoded in ID.
REQ-017 if_instr, if_npc, if_taken  out  32/32/1  IF/ID write data.
REQ-018 if_en, if_flush  out  1/1  IF/ID write enable and bubble insert.

Function
REQ-019 The unit SHALL hold state in these registers: PC (32 bits), halted (1 bit), and per BTB entry a valid bit, tag PC[31:IW+2], target (32 bits) and a 2-bit counter.
REQ-020 IW SHALL equal log2(BTB_ENTRIES), and the BTB index SHALL be PC[IW+1:2].
REQ-021 Lookup SHALL be combinational on PC; hit means valid and tag match.
REQ-022 pred_taken SHALL be hit AND counter>=2; pred_next SHALL be the stored target if pred_taken, else PC+4 (32-bit, wraps mod 2^32).
REQ-023 if_instr SHALL equal imemload, if_npc SHALL equal PC+4, and if_taken SHALL equal pred_taken.
REQ-024 imemREN SHALL equal ~halted AND ~RST.
REQ-025 Per-cycle priority (first match wins):
- RST: reset (REQ-031).
- ex_redirect: PC<=ex_target; halted<=0; if_en=1; if_flush=1.
- stall: PC held; if_en=0; if_flush=0.
- halted OR halt: halted<=1; PC held; if_en=1; if_flush=1.
- ~ihit: PC held; if_en=1; if_flush=1 (bubble).
- ihit: PC<=pred_next; if_en=1; if_flush=0.
REQ-026 Redirect SHALL override stall, halt and ihit in the same cycle, and any ihit data that cycle SHALL be discarded.
REQ-027 BTB update on btb_upd, at index and tag derived from btb_upd_pc:
- hit and taken: counter saturating increment to max 3; target<=btb_upd_target.
- hit and not-taken: counter saturating decrement to min 0; target unchanged.
- miss and taken: valid<=1; tag and target written; counter<=2.
- miss and not-taken: no change.
REQ-028 A lookup and an update to the same entry in the same cycle SHALL read the pre-update contents; the new value SHALL be visible from the next cycle.
REQ-029 BTB updates SHALL proceed regardless of stall, halt or redirect.
REQ-030 Fetch latency SHALL be combinational: ihit in cycle N SHALL write IF/ID at the end of cycle N.

Reset
REQ-031 While RST=1 at a rising edge, the unit SHALL set PC<=PC_INIT, halted<=0, all valid bits<=0 and all counters<=0; while RST=1, if_en=1, if_flush=1 and imemREN=0.
REQ-032 Reset asserted mid-stall, mid-halt or mid-update SHALL take precedence; a btb_upd in a reset cycle SHALL be ignored.

Verification
REQ-033 Reset, then ihit=1 every cycle with no branches -> imemaddr sequence 0,4,8,12; if_npc=4,8,12,16; if_taken=0.
REQ-034 Three btb_upd strobes with pc=0x10, target=0x40, taken=1, then fetch at 0x10 -> if_taken=1, next imemaddr=0x40, counter=3; then two not-taken updates -> counter=1, fetch at 0x10 predicts 0x14.
REQ-035 stall=1 and ex_redirect=1 with ex_target=0x200 in the same cycle -> if_en=1, if_flush=1, next PC=0x200.
REQ-036 halt=1 at PC=0x20 -> imemREN=0 from the next cycle, PC stays 0x20, and bubbles are inserted; a later ex_redirect to 0x80 -> halted cleared and fetch resumes at 0x80.
REQ-037 ihit=0 for 3 cycles at PC=0x8 -> three bubbles with PC held at 0x8; on ihit=1 -> the instruction is latched and PC=0xC.
REQ-038 PC=0xFFFF_FFFC with ihit=1 and no BTB hit -> next PC=0x0000_0000 and if_npc=0.

Source files
------------

// File: rtl/fetch_unit.sv
// IF stage with a direct-mapped BTB/2-bit predictor; fetch-to-IF/ID is combinational (zero-cycle).
// Backpressure: stall freezes PC and IF/ID; ~ihit inserts bubbles; redirect overrides both.
module fetch_unit #(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        btb_upd,
  input  logic [31:0] btb_upd_pc,
  input  logic [31:0] btb_upd_target,
  input  logic        btb_upd_taken,
  input  logic        halt,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc,
  output logic        if_taken,
  output logic        if_en,
  output logic        if_flush
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  typedef struct packed {
    logic          vld;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
    logic [1:0]    cnt;
  } btb_ent_t;

  btb_ent_t btb [BTB_ENTRIES];

  logic [31:0]   pc, pc_nxt, pc_plus4, pred_next;
  logic          halted, halted_nxt;
  logic [IW-1:0] idx, uidx;
  logic [TW-1:0] utag;
  logic          hit, uhit, pred_taken;
  logic [1:0]    unused_pc_lsbs;

  assign unused_pc_lsbs = btb_upd_pc[1:0];

  assign idx        = pc[IW+1:2];
  assign hit        = btb[idx].vld && (btb[idx].tag == pc[31:IW+2]);
  assign pred_taken = hit && btb[idx].cnt[1];
  assign pc_plus4   = pc + 32'd4;
  assign pred_next  = pred_taken ? btb[idx].tgt : pc_plus4;

  assign uidx = btb_upd_pc[IW+1:2];
  assign utag = btb_upd_pc[31:IW+2];
  assign uhit = btb[uidx].vld && (btb[uidx].tag == utag);

  assign imemREN  = ~halted & ~RST;
  assign imemaddr = pc;
  assign if_instr = imemload;
  assign if_npc   = pc_plus4;
  assign if_taken = pred_taken;

  always_comb begin
    pc_nxt     = pc;
    halted_nxt = halted;
    if_en      = 1'b1;
    if_flush   = 1'b1;
    if (RST) begin
      pc_nxt     = PC_INIT;
      halted_nxt = 1'b0;
    end else if (ex_redirect) begin
      pc_nxt     = ex_target;
      halted_nxt = 1'b0;
    end else if (stall) begin
      if_en    = 1'b0;
      if_flush = 1'b0;
    end else if (halted || halt) begin
      halted_nxt = 1'b1;
    end else if (ihit) begin
      pc_nxt   = pred_next;
      if_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc     <= PC_INIT;
      halted <= 1'b0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i].vld <= 1'b0;
        btb[i].cnt <= 2'd0;
      end
    end else begin
      pc     <= pc_nxt;
      halted <= halted_nxt;
      // Updates are independent of the fetch path: stall/halt/redirect never block training.
      if (btb_upd) begin
        if (uhit && btb_upd_taken) begin
          if (btb[uidx].cnt != 2'd3) btb[uidx].cnt <= btb[uidx].cnt + 2'd1;
          btb[uidx].tgt <= btb_upd_target;
        end else if (uhit) begin
          if (btb[uidx].cnt != 2'd0) btb[uidx].cnt <= btb[uidx].cnt - 2'd1;
        end else if (btb_upd_taken) begin
          btb[uidx].vld <= 1'b1;
          btb[uidx].tag <= utag;
          btb[uidx].tgt <= btb_upd_target;
          btb[uidx].cnt <= 2'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed stimulus with a scoreboard queue; a negedge monitor checks every presented cycle.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        btb_upd;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic        halt;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        if_taken;
  logic        if_en;
  logic        if_flush;

  fetch_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .stall(stall),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .btb_upd(btb_upd), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .halt(halt), .if_instr(if_instr), .if_npc(if_npc), .if_taken(if_taken),
    .if_en(if_en), .if_flush(if_flush)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic        en;
    logic        fl;
    logic [31:0] npc;
    logic        tk;
    logic [31:0] instr;
    int          id;
  } exp_t;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;
  int   nstep = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("imemaddr", e.id, imemaddr, e.addr);
      chk("imemREN",  e.id, {31'd0, imemREN}, {31'd0, e.ren});
      chk("if_en",    e.id, {31'd0, if_en},   {31'd0, e.en});
      chk("if_flush", e.id, {31'd0, if_flush},{31'd0, e.fl});
      chk("if_npc",   e.id, if_npc, e.npc);
      chk("if_taken", e.id, {31'd0, if_taken},{31'd0, e.tk});
      chk("if_instr", e.id, if_instr, e.instr);
    end
  end

  // Drive one cycle's inputs, record the expected outputs, then advance past the next edge.
  task automatic step(input logic ih, input logic st, input logic rd, input logic [31:0] tg,
                      input logic hl, input logic [31:0] ea, input logic er, input logic een,
                      input logic efl, input logic [31:0] enpc, input logic etk);
    exp_t e;
    ihit        = ih;
    stall       = st;
    ex_redirect = rd;
    ex_target   = tg;
    halt        = hl;
    imemload    = 32'hC0DE_0000 + nstep;
    e.addr = ea; e.ren = er; e.en = een; e.fl = efl; e.npc = enpc; e.tk = etk;
    e.instr = imemload; e.id = nstep;
    sb.push_back(e);
    nstep++;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] p, input logic [31:0] t, input logic tk);
    btb_upd = v; btb_upd_pc = p; btb_upd_target = t; btb_upd_taken = tk;
  endtask

  initial begin
    RST = 1'b1; ihit = 0; imemload = 0; stall = 0; ex_redirect = 0; ex_target = 0; halt = 0;
    set_upd(0, 0, 0, 0);
    @(posedge CLK);
    #1;
    // reset state
    step(0,0,0,0,0,            32'h0, 0,1,1, 32'h4, 0);
    RST = 1'b0;
    // sequential fetch, then three ihit=0 bubbles at 0x8
    step(1,0,0,0,0,            32'h0, 1,1,0, 32'h4, 0);
    step(1,0,0,0,0,            32'h4, 1,1,0, 32'h8, 0);
    for (int i = 0; i < 3; i++)
      step(0,0,0,0,0,          32'h8, 1,1,1, 32'hC, 0);
    step(1,0,0,0,0,            32'h8, 1,1,0, 32'hC, 0);
    step(1,0,0,0,0,            32'hC, 1,1,0, 32'h10, 0);
    // train 0x10 -> 0x40 while stalled; lookups see pre-update contents
    set_upd(1, 32'h10, 32'h40, 1);
    step(0,1,0,0,0,            32'h10, 1,0,0, 32'h14, 0);
    step(0,1,0,0,0,            32'h10, 1,0,0, 32'h14, 1);
    step(0,1,0,0,0,            32'h10, 1,0,0, 32'h14, 1);
    set_upd(0, 0, 0, 0);
    step(1,0,0,0,0,            32'h10, 1,1,0, 32'h14, 1);
    // two not-taken updates drop the saturated counter to 1
    set_upd(1, 32'h10, 32'h40, 0);
    step(0,1,0,0,0,            32'h40, 1,0,0, 32'h44, 0);
    step(0,1,0,0,0,            32'h40, 1,0,0, 32'h44, 0);
    set_upd(0, 0, 0, 0);
    step(0,0,1,32'h10,0,       32'h40, 1,1,1, 32'h44, 0);
    step(1,0,0,0,0,            32'h10, 1,1,0, 32'h14, 0);
    // redirect beats stall and ihit
    step(1,1,1,32'h200,0,      32'h14, 1,1,1, 32'h18, 0);
    step(0,0,1,32'h20,0,       32'h200,1,1,1, 32'h204,0);
    // halt at 0x20, then redirect out to 0x80
    step(1,0,0,0,1,            32'h20, 1,1,1, 32'h24, 0);
    step(1,0,0,0,0,            32'h20, 0,1,1, 32'h24, 0);
    step(1,0,0,0,0,            32'h20, 0,1,1, 32'h24, 0);
    step(1,0,1,32'h80,0,       32'h20, 0,1,1, 32'h24, 0);
    step(1,0,0,0,0,            32'h80, 1,1,0, 32'h84, 0);
    // PC wrap at the top of the address space
    step(0,0,1,32'hFFFF_FFFC,0,32'h84, 1,1,1, 32'h88, 0);
    step(1,0,0,0,0,     32'hFFFF_FFFC, 1,1,0, 32'h0,  0);
    step(0,0,0,0,0,            32'h0,  1,1,1, 32'h4,  0);
    // reset beats stall, halt and a same-cycle BTB update
    RST = 1'b1;
    set_upd(1, 32'h0, 32'h100, 1);
    step(1,1,0,0,1,            32'h0,  0,1,1, 32'h4,  0);
    RST = 1'b0;
    set_upd(0, 0, 0, 0);
    step(1,0,0,0,0,            32'h0,  1,1,0, 32'h4,  0);
    step(0,0,0,0,0,            32'h4,  1,1,1, 32'h8,  0);
    @(negedge CLK);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
